seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 86 ++++++++
 tb/tb_seq_divider.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, with divide-by-zero shortcut.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         valid,
  output logic         busy,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [N-1:0] d;
  logic [N-1:0] q;
  // The partial remainder always ends each step below the divisor, so its
  // top bit is zero and only N bits are stored; the step itself is N+1 wide.
  logic [N-1:0] r;
  logic [N:0] shifted;
  logic [N:0] trial;
  logic neg;
  logic [N-1:0] r_next;
  logic [N-1:0] q_next;
  always_comb begin
    shifted = {r, q[N-1]};
    trial = shifted - {1'b0, d};
    neg = trial[N];
    r_next = neg ? shifted[N-1:0] : trial[N-1:0];
    q_next = {q[N-2:0], ~neg};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      d <= '0;
      q <= '0;
      r <= '0;
      quotient <= '0;
      remainder <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && divisor == '0) begin
            state <= DONE;
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
            valid <= 1'b1;
          end else if (start) begin
            state <= CALC;
            d <= divisor;
            q <= dividend;
            r <= '0;
            count <= CW'(N);
            busy <= 1'b1;
            valid <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          r <= r_next;
          q <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= DONE;
            busy <= 1'b0;
            valid <= 1'b1;
            div_by_zero <= 1'b0;
            quotient <= q_next;
            remainder <= r_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table, hand sequences for abort/overlap, and a random sweep.
module tb_seq_divider;
  localparam int N = 32;
  logic clock;
  logic reset;
  logic start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic valid;
  logic busy;
  logic div_by_zero;
  int checks = 0;
  int errors = 0;

  seq_divider #(.N(N)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .valid(valid),
    .busy(busy),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic z;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launches one division (optionally in the current timestep) and checks
  // latency, busy duration, result hold during CALC and the final result.
  // disturb>0 re-asserts start with different operands at that sample.
  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] eq, input logic [N-1:0] er,
                     input logic ez, input int disturb, input bit now);
    int k;
    int bc;
    logic held;
    logic [N-1:0] q0;
    logic [N-1:0] r0;
    if (!now) @(negedge clock);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 1;
    bc = 0;
    held = 1'b1;
    q0 = quotient;
    r0 = remainder;
    if (!ez) chk("accept_valid_low", 64'(valid), 64'(0));
    while (!valid && k < 60) begin
      if (busy) bc++;
      if (quotient !== q0 || remainder !== r0) held = 1'b0;
      if (k == disturb) begin
        start = 1'b1;
        dividend = ~a;
        divisor = b + 3;
      end else if (k == disturb + 1) start = 1'b0;
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    chk("latency", 64'(k), ez ? 64'(1) : 64'(N + 1));
    chk("busy_cycles", 64'(bc), ez ? 64'(0) : 64'(N));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("held_in_calc", 64'(held), 64'(1));
    chk("quotient", 64'(quotient), 64'(eq));
    chk("remainder", 64'(remainder), 64'(er));
    chk("div_by_zero", 64'(div_by_zero), 64'(ez));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_quotient"}, 64'(quotient), 64'(0));
    chk({tag, "_remainder"}, 64'(remainder), 64'(0));
    chk({tag, "_valid"}, 64'(valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(0));
  endtask

  initial begin
    vec_t v[12];
    logic seen;
    logic [N-1:0] a;
    logic [N-1:0] b;
    v[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    v[1]  = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    v[2]  = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    v[3]  = '{32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0};
    v[4]  = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
    v[5]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1};
    v[6]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    v[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
    v[8]  = '{32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0};
    v[9]  = '{32'd1000, 32'd10, 32'd100, 32'd0, 1'b0};
    v[10] = '{32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0};
    v[11] = '{32'h80000000, 32'd3, 32'h2AAAAAAA, 32'd2, 1'b0};
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, -1, 1'b1);
    foreach (v[i]) run(v[i].a, v[i].b, v[i].q, v[i].r, v[i].z, -1, 1'b0);
    run(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 10, 1'b0);
    @(negedge clock);
    dividend = 32'd1000;
    divisor = 32'd10;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_zero("abort");
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (valid) seen = 1'b1;
    end
    chk("no_valid_after_abort", 64'(seen), 64'(0));
    run(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(31, 0);
      if (b == '0) b = 32'd1;
      run(a, b, a / b, a % b, 1'b0, -1, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
